pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, 32, payload bit width (at least 1).
REQ-002 Parameter BUBBLE, '0 (WIDTH bits), payload value loaded on reset and on flush.
REQ-003 Parameter CNT_W, 16, perf counter width (at least 2).
REQ-004 Port CLK  in  1  single clock, all state updates on its rising edge.
REQ-005 Port nRST  in  1  asynchronous active-low reset.
REQ-006 Port flush_branch  in  1  unconditional flush request.
REQ-007 Port flush  in  1  hit-gated flush request.
REQ-008 Port mem_op  in  1  a memory operation is outstanding downstream.
REQ-009 Port ihit  in  1  instruction cache hit.
REQ-010 Port dhit  in  1  data cache hit.
REQ-011 Port stall  in  1  hazard stall.
REQ-012 Port valid_in  in  1  the upstream payload is valid.
REQ-013 Port data_in  in  WIDTH  upstream payload.
REQ-014 Port valid_out  out  1  the registered payload is valid.
REQ-015 Port data_out  out  WIDTH  registered payload.
REQ-016 Port load_out  out  1  combinational strobe, high when this cycle's edge loads data_in.
REQ-017 Port flush_pend  out  1  a deferred flush is pending.
REQ-018 Port stall_cnt  out  CNT_W  saturating count of held-valid cycles.
REQ-019 Port bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Function
REQ-020 Gate definitions: gate = ihit & (~mem_op | dhit); adv = gate & ~stall.
REQ-021 Update priority per edge (highest first):
- flush_branch: load bubble, clear pending.
- (flush | flush_pend) & gate: load bubble, clear pending; stall is ignored.
- flush & ~gate: hold the register, set pending.
- adv: load data_in and valid_in.
- otherwise: hold.
REQ-022 A bubble sets data_out=BUBBLE and valid_out=0.
REQ-023 The pending-flush FSM has two states:
- IDLE -> PEND on flush & ~gate & ~flush_branch.
- PEND -> IDLE on gate or on flush_branch.
- PEND ignores a repeated flush while gate stays low.
REQ-024 load_out = adv & ~flush_branch & ~((flush | flush_pend) & gate) & ~flush.
REQ-025 Load latency is one cycle: data_in sampled at edge N appears on data_out after edge N.
REQ-026 stall_cnt increments on each edge where valid_out=1 before the edge and the register holds; it saturates at all-ones.
REQ-027 bubble_cnt increments on each edge that loads a bubble; it saturates at all-ones.
REQ-028 Counters do not wrap.
REQ-029 When flush and flush_branch are asserted together, one bubble is loaded and counted once.

Reset
REQ-030 While nRST=0, independent of CLK, the block holds:
- data_out=BUBBLE, valid_out=0;
- FSM=IDLE, flush_pend=0;
- stall_cnt=0, bubble_cnt=0.
REQ-031 Reset asserted mid-operation discards any pending flush and clears both counters.
REQ-032 The first edge after nRST rises follows REQ-021 normally.

Configuration
REQ-033 Macro PIPE_STAGE_PERF_EN: when defined, both counters are implemented per REQ-026 and REQ-027.
REQ-034 When PIPE_STAGE_PERF_EN is not defined, stall_cnt and bubble_cnt are constant 0 and no counter flops exist; all other behaviour is identical.

Structure
REQ-035 Package pipe_stage_pkg holds:
- typedef pend_state_t {IDLE, PEND};
- typedef upd_kind_t {UPD_HOLD, UPD_LOAD, UPD_BUBBLE};
- a default CNT_W constant.
REQ-036 Sub-module sat_counter (parameter CNT_W; ports CLK, nRST, inc, count) is instantiated twice, only under PIPE_STAGE_PERF_EN.
REQ-037 The update-kind decode is a single combinational block that feeds both the register and the counters.

Verification
REQ-038 Load: ihit=1, mem_op=0, stall=0, valid_in=1, data_in=0xDEADBEEF -> after 1 edge, data_out=0xDEADBEEF, valid_out=1, load_out was 1.
REQ-039 Memory gating: mem_op=1, ihit=1, dhit=0 for 3 edges -> data_out holds and stall_cnt=3; with dhit=1 on the 4th edge -> new data loads.
REQ-040 Deferred flush: flush=1, ihit=0 for 1 edge, then flush=0 -> flush_pend=1 and data held; next edge with ihit=1 -> bubble loaded, flush_pend=0, bubble_cnt=1.
REQ-041 Branch priority: flush_branch=1 with stall=1, ihit=0, flush_pend=1 -> one edge gives valid_out=0, data_out=BUBBLE, flush_pend=0.
REQ-042 Saturation: CNT_W=2, hold a valid payload for 5 edges -> stall_cnt=3; then pulse nRST low asynchronously mid-cycle -> all outputs reset immediately.
REQ-043 Build without PIPE_STAGE_PERF_EN -> counters read 0 across all the scenarios above, with identical data_out and valid_out traces.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// ============================================================================
// pipe_stage_pkg -- shared types and defaults for the pipe_stage_reg slice
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_stage_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pend_state_t;

  typedef enum logic [1:0] {
    UPD_HOLD   = 2'd0,
    UPD_LOAD   = 2'd1,
    UPD_BUBBLE = 2'd2
  } upd_kind_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter -- up-counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg -- pipeline register with cache-hit gating, deferred flush
// and optional perf counters (enabled by macro PIPE_STAGE_PERF_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush_branch,
  input  logic             flush,
  input  logic             mem_op,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             stall,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             load_out,
  output logic             flush_pend,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             gate;
  logic             adv;
  upd_kind_t        kind;
  pend_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign gate = ihit & (~mem_op | dhit);
  assign adv  = gate & ~stall;

  // Single priority decode; register, FSM and counters all follow it.
  always_comb begin
    kind    = UPD_HOLD;
    state_d = state_q;
    if (flush_branch) begin
      kind    = UPD_BUBBLE;
      state_d = IDLE;
    end else if ((flush || (state_q == PEND)) && gate) begin
      kind    = UPD_BUBBLE;
      state_d = IDLE;
    end else if (flush) begin
      kind    = UPD_HOLD;
      state_d = PEND;
    end else if (adv) begin
      kind    = UPD_LOAD;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (kind)
      UPD_LOAD: begin
        data_d  = data_in;
        valid_d = valid_in;
      end
      UPD_BUBBLE: begin
        data_d  = BUBBLE;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      data_q  <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign load_out   = (kind == UPD_LOAD);
  assign flush_pend = (state_q == PEND);

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  // A stall cycle is a held edge while a valid payload sits in the register.
  assign stall_inc  = valid_q & (kind == UPD_HOLD);
  assign bubble_inc = (kind == UPD_BUBBLE);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

`default_nettype wire
